// File: rtl/auth_tag_top.sv
`default_nettype none
// ============================================================================
// Module   : auth_tag_top
// Desc     : Message-authentication tag engine: six GF(2^32) lane hashes,
//            40x192 Toeplitz compression and a one-time-pad XOR.
//            Optional build macro AUTH_STATUS_REG_EN adds a status register.
// Revision : 1.0 - initial release
// ============================================================================
module auth_tag_top #(
    parameter int TOEP_COLS_PER_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  ss_tdata,
    input  logic        ss_tvalid,
    output logic        ss_tready,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [63:0] wdata,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [39:0] sm_tdata,
    output logic        sm_tvalid,
    input  logic        sm_tready
);

    localparam logic [31:0] c_poly     = 32'h0040_0007;
    localparam logic [7:0]  c_step     = 8'(TOEP_COLS_PER_CYC);
    localparam logic [7:0]  c_last_col = 8'(192 - TOEP_COLS_PER_CYC);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_OUT     = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [185:0]      r_pk;
    logic [230:0]      r_tk;
    logic [39:0]       r_otp;
    logic [5:0][31:0]  r_acc;
    logic [31:0]       w_key     [6];
    logic [31:0]       w_acc_nxt [6];
    logic [191:0]      w_p;
    logic [7:0]        r_col;
    logic [39:0]       r_h;
    logic [39:0]       w_fold;
    logic [7:0]        w_c;
    logic [7:0]        w_tk_lo;
    logic              r_aw_full;
    logic [31:0]       r_aw_addr;
    logic [31:0]       w_waddr;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              r_rvalid;
    logic [63:0]       r_rdata;
    logic [63:0]       w_rd_data;
    logic              w_byte_acc;
    logic              w_tag_hs;

    // MSB-first shift-and-add multiply with on-the-fly reduction.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = '0;
        for (int i = 31; i >= 0; i--) begin
            p = {p[30:0], 1'b0} ^ (p[31] ? c_poly : 32'h0);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_COMPUTE;
            S_COMPUTE: if (r_col == c_last_col) w_state_nxt = S_OUT;
            S_OUT:     if (sm_tready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ss_tready = (r_state == S_IDLE);
        sm_tvalid = (r_state == S_OUT);
    end

    assign w_byte_acc = ss_tready & ss_tvalid & ~start;
    assign w_tag_hs   = sm_tvalid & sm_tready;

    // ------------------------------------------------------------------
    // Lane hashes
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 6; gi++) begin : g_lane
        assign w_key[gi]     = {1'b0, r_pk[31*gi +: 31]};
        assign w_acc_nxt[gi] = gf_mul(r_acc[gi] ^ {24'h0, ss_tdata}, w_key[gi]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_byte_acc) begin
            for (int i = 0; i < 6; i++) r_acc[i] <= w_acc_nxt[i];
        end else if (w_tag_hs) begin
            r_acc <= '0;
        end
    end

    assign w_p = r_acc;

    // ------------------------------------------------------------------
    // Toeplitz compression: column c adds TK[191-c +: 40] when P[c] is set
    // ------------------------------------------------------------------
    always_comb begin
        w_fold  = '0;
        w_c     = '0;
        w_tk_lo = '0;
        for (int j = 0; j < TOEP_COLS_PER_CYC; j++) begin
            w_c     = r_col + 8'(j);
            w_tk_lo = 8'd191 - w_c;
            if (w_p[w_c]) w_fold = w_fold ^ r_tk[w_tk_lo +: 40];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col <= '0;
            r_h   <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_col <= '0;
            r_h   <= '0;
        end else if (r_state == S_COMPUTE) begin
            r_col <= r_col + c_step;
            r_h   <= r_h ^ w_fold;
        end
    end

    // OTP is applied live so a late OTP write is reflected in the tag.
    assign sm_tdata = r_h ^ r_otp;

    // ------------------------------------------------------------------
    // Register write channel
    // ------------------------------------------------------------------
    assign awready = ~r_aw_full;
    assign wready  = r_aw_full | awvalid;
    assign w_aw_hs = awvalid & awready;
    assign w_w_hs  = wvalid & wready;
    assign w_waddr = r_aw_full ? r_aw_addr : awaddr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_full <= 1'b0;
            r_aw_addr <= '0;
        end else if (w_w_hs) begin
            r_aw_full <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_addr <= awaddr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pk  <= '0;
            r_tk  <= '0;
            r_otp <= '0;
        end else if (w_w_hs) begin
            case (w_waddr)
                32'h00:  r_pk[63:0]    <= wdata;
                32'h08:  r_pk[127:64]  <= wdata;
                32'h10:  r_pk[185:128] <= wdata[57:0];
                32'h18:  r_tk[63:0]    <= wdata;
                32'h20:  r_tk[127:64]  <= wdata;
                32'h28:  r_tk[191:128] <= wdata;
                32'h30:  r_tk[230:192] <= wdata[38:0];
                32'h38:  r_otp         <= wdata[39:0];
                default: ;
            endcase
        end
    end

`ifdef AUTH_STATUS_REG_EN
    logic [31:0] r_byte_cnt;
    logic        w_busy;

    assign w_busy = (r_state == S_COMPUTE) | (r_state == S_OUT);

    always_ff @(posedge clk) begin
        if (!rst_n)          r_byte_cnt <= '0;
        else if (w_tag_hs)   r_byte_cnt <= '0;
        else if (w_byte_acc) r_byte_cnt <= r_byte_cnt + 32'd1;
    end
`endif

    // ------------------------------------------------------------------
    // Register read channel
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        case (araddr)
            32'h00:  w_rd_data = r_pk[63:0];
            32'h08:  w_rd_data = r_pk[127:64];
            32'h10:  w_rd_data = {6'h0, r_pk[185:128]};
            32'h18:  w_rd_data = r_tk[63:0];
            32'h20:  w_rd_data = r_tk[127:64];
            32'h28:  w_rd_data = r_tk[191:128];
            32'h30:  w_rd_data = {25'h0, r_tk[230:192]};
            32'h38:  w_rd_data = {24'h0, r_otp};
`ifdef AUTH_STATUS_REG_EN
            32'h40:  w_rd_data = {r_byte_cnt, 30'h0, sm_tvalid, w_busy};
`endif
            default: w_rd_data = '0;
        endcase
    end

    assign arready = ~r_rvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_auth_tag_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_auth_tag_top
// Desc     : Self-checking bench for auth_tag_top against a bit-level
//            reference model of the tag rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_auth_tag_top;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  ss_tdata;
    logic        ss_tvalid;
    logic        ss_tready;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [39:0] sm_tdata;
    logic        sm_tvalid;
    logic        sm_tready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [185:0] m_pk;
    logic [230:0] m_tk;
    logic [39:0]  m_otp;
    logic [7:0]   m_msg [$];

    auth_tag_top #(.TOEP_COLS_PER_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carry-less product followed by long division by x^32+x^22+x^2+x+1.
    function automatic logic [31:0] gf_ref(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        prod = '0;
        for (int i = 0; i < 32; i++)
            if (b[i]) prod = prod ^ ({32'h0, a} << i);
        for (int k = 62; k >= 32; k--)
            if (prod[k]) prod = prod ^ (64'h1_0040_0007 << (k - 32));
        return prod[31:0];
    endfunction

    function automatic logic [39:0] ref_tag();
        logic [31:0]  a [6];
        logic [31:0]  key;
        logic [191:0] p;
        logic [39:0]  h;
        for (int i = 0; i < 6; i++) a[i] = '0;
        foreach (m_msg[n])
            for (int i = 0; i < 6; i++) begin
                key  = {1'b0, m_pk[31*i +: 31]};
                a[i] = gf_ref(a[i] ^ {24'h0, m_msg[n]}, key);
            end
        for (int i = 0; i < 6; i++) p[32*i +: 32] = a[i];
        for (int r = 0; r < 40; r++) begin
            h[r] = 1'b0;
            for (int c = 0; c < 192; c++) h[r] = h[r] ^ (m_tk[r + 191 - c] & p[c]);
        end
        return h ^ m_otp;
    endfunction

    function automatic logic [63:0] exp_status();
`ifdef AUTH_STATUS_REG_EN
        return {32'(m_msg.size()), 32'h0};
`else
        return 64'h0;
`endif
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [63:0] d);
        case (a)
            32'h00:  m_pk[63:0]    = d;
            32'h08:  m_pk[127:64]  = d;
            32'h10:  m_pk[185:128] = d[57:0];
            32'h18:  m_tk[63:0]    = d;
            32'h20:  m_tk[127:64]  = d;
            32'h28:  m_tk[191:128] = d;
            32'h30:  m_tk[230:192] = d[38:0];
            32'h38:  m_otp         = d[39:0];
            default: ;
        endcase
    endtask

    function automatic logic [63:0] model_read(input logic [31:0] a);
        case (a)
            32'h00:  return m_pk[63:0];
            32'h08:  return m_pk[127:64];
            32'h10:  return {6'h0, m_pk[185:128]};
            32'h18:  return m_tk[63:0];
            32'h20:  return m_tk[127:64];
            32'h28:  return m_tk[191:128];
            32'h30:  return {25'h0, m_tk[230:192]};
            32'h38:  return {24'h0, m_otp};
            32'h40:  return exp_status();
            default: return 64'h0;
        endcase
    endfunction

    task automatic write_together(input logic [31:0] a, input logic [63:0] d);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a, d);
    endtask

    task automatic write_split(input logic [31:0] a, input logic [63:0] d);
        awvalid = 1'b1; awaddr = a;
        tick();
        awvalid = 1'b0;
        #1;
        check("aw_latched_awready", 64'(awready), 64'd0);
        check("aw_latched_wready", 64'(wready), 64'd1);
        repeat (3) tick();
        wvalid = 1'b1; wdata = d;
        tick();
        wvalid = 1'b0;
        #1;
        check("w_done_awready", 64'(awready), 64'd1);
        model_write(a, d);
    endtask

    task automatic read_check(input logic [31:0] a, input logic [63:0] exp);
        arvalid = 1'b1; araddr = a;
        #1;
        check("arready_idle", 64'(arready), 64'd1);
        tick();
        arvalid = 1'b0;
        check("rvalid_after_ar", 64'(rvalid), 64'd1);
        check($sformatf("rdata_%0h", a), rdata, exp);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_cleared", 64'(rvalid), 64'd0);
        check("rdata_held", rdata, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ss_tvalid = 1'b1; ss_tdata = b;
        tick();
        ss_tvalid = 1'b0;
        m_msg.push_back(b);
    endtask

    // Closes the message, waits for the tag and drains it.
    task automatic run_tag(input bit with_byte, input logic [7:0] b, input int mid_start, input int hold);
        logic [39:0] exp;
        int          cyc;
        exp   = ref_tag();
        start = 1'b1;
        if (with_byte) begin ss_tvalid = 1'b1; ss_tdata = b; end
        #1;
        check("ss_tready_at_start", 64'(ss_tready), 64'd1);
        tick();
        start = 1'b0; ss_tvalid = 1'b0;
        cyc = 1;
        check("ss_tready_compute", 64'(ss_tready), 64'd0);
        while (sm_tvalid !== 1'b1 && cyc < 60) begin
            start = (cyc == mid_start);
            tick();
            cyc++;
        end
        start = 1'b0;
        check("tag_latency", 64'(cyc), 64'd25);
        check("tag_value", 64'(sm_tdata), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            tick();
            check("tag_stable", 64'(sm_tdata), 64'(exp));
            check("tvalid_held", 64'(sm_tvalid), 64'd1);
            check("ss_tready_out", 64'(ss_tready), 64'd0);
        end
        sm_tready = 1'b1;
        tick();
        sm_tready = 1'b0;
        check("tvalid_drop", 64'(sm_tvalid), 64'd0);
        check("ss_tready_back", 64'(ss_tready), 64'd1);
        m_msg.delete();
    endtask

    initial begin
        logic [185:0] pk_ones;
        int           len;

        rst_n = 1'b0; start = 1'b0; ss_tdata = '0; ss_tvalid = 1'b0;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0; sm_tready = 1'b0;
        m_pk = '0; m_tk = '0; m_otp = '0;
        repeat (3) tick();
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_ss_tready", 64'(ss_tready), 64'd1);
        check("rst_sm_tvalid", 64'(sm_tvalid), 64'd0);
        check("rst_rdata", rdata, 64'h0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 8; k++) read_check(32'(8 * k), 64'h0);

        for (int k = 0; k < 8; k++) write_together(32'(8 * k), {$urandom(), $urandom()});
        for (int k = 0; k < 8; k++) read_check(32'(8 * k), model_read(32'(8 * k)));
        for (int k = 0; k < 8; k++) write_split(32'(8 * k), {$urandom(), $urandom()});
        for (int k = 0; k < 8; k++) read_check(32'(8 * k), model_read(32'(8 * k)));

        write_together(32'h10, 64'hFFFF_FFFF_FFFF_FFFF);
        read_check(32'h10, 64'h03FF_FFFF_FFFF_FFFF);
        write_split(32'h30, 64'hFFFF_FFFF_FFFF_FFFF);
        read_check(32'h30, 64'h0000_007F_FFFF_FFFF);
        write_together(32'h48, 64'hDEAD_BEEF_0000_0001);
        write_together(32'h40, 64'hFFFF_FFFF_FFFF_FFFF);
        read_check(32'h48, 64'h0);
        read_check(32'h40, exp_status());
        for (int k = 0; k < 8; k++) read_check(32'(8 * k), model_read(32'(8 * k)));

        // Empty message: tag equals the pad.
        write_together(32'h38, 64'h12_3456_78AB);
        run_tag(1'b0, 8'h0, -1, 0);
        run_tag(1'b0, 8'h0, -1, 0);

        // Unit lane keys, single Toeplitz diagonal.
        pk_ones = '0;
        for (int i = 0; i < 6; i++) pk_ones[31*i] = 1'b1;
        write_together(32'h00, pk_ones[63:0]);
        write_together(32'h08, pk_ones[127:64]);
        write_together(32'h10, {6'h0, pk_ones[185:128]});
        write_together(32'h18, 64'h0);
        write_together(32'h20, 64'h0);
        write_together(32'h28, 64'h8000_0000_0000_0000);
        write_together(32'h30, 64'h0);
        write_together(32'h38, 64'hFF);
        send_byte(8'h5A);
        send_byte(8'h3C);
        run_tag(1'b0, 8'h0, -1, 10);
        run_tag(1'b0, 8'h0, -1, 0);

        // Random keys and messages, including ignored mid-compute start.
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 8; k++) write_together(32'(8 * k), {$urandom(), $urandom()});
            len = int'($urandom_range(1, 12));
            for (int n = 0; n < len; n++) begin
                send_byte(8'($urandom()));
                repeat ($urandom_range(0, 2)) tick();
            end
            read_check(32'h40, exp_status());
            run_tag(1'b0, 8'h0, (t == 1) ? 5 : -1, int'($urandom_range(0, 3)));
        end

        // Start together with a byte: the byte is excluded.
        send_byte(8'hC3);
        send_byte(8'h17);
        run_tag(1'b1, 8'hE9, -1, 1);

        // Reset during COMPUTE drops the tag and clears the keys.
        send_byte(8'h81);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_pk = '0; m_tk = '0; m_otp = '0;
        m_msg.delete();
        check("abort_sm_tvalid", 64'(sm_tvalid), 64'd0);
        check("abort_ss_tready", 64'(ss_tready), 64'd1);
        read_check(32'h38, 64'h0);
        write_together(32'h38, 64'hA5_5A5A_A5A5);
        run_tag(1'b0, 8'h0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
